clock_set_ctrl: RTL

//   Controller for the 12-hour BCD clock (hh/mm/ss/pm). Generates the clock's ena

---
 rtl/clock_set_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: tick prescaler and two-button set-time FSM for a 12-hour BCD clock.
// In RUN the prescaler paces the clock's ena. mode_btn freezes the clock and captures
// the current time into shadow registers. inc_btn edits hours, then minutes. The final
// mode_btn press commits the shadow values with a single-cycle load strobe.
module clock_set_ctrl #(
   parameter int TICK_DIV = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_btn,
   input  logic       inc_btn,
   input  logic [7:0] cur_hh,
   input  logic [7:0] cur_mm,
   input  logic       cur_pm,
   output logic       ena,
   output logic       load,
   output logic [7:0] load_hh,
   output logic [7:0] load_mm,
   output logic       load_pm,
   output logic [1:0] state
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   localparam logic [1:0] ST_RUN    = 2'b00;
   localparam logic [1:0] ST_SET_HH = 2'b01;
   localparam logic [1:0] ST_SET_MM = 2'b10;
   localparam logic [1:0] ST_COMMIT = 2'b11;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             ena_q,   ena_d;
   logic             load_q,  load_d;
   logic [7:0]       hh_q,    hh_d;
   logic [7:0]       mm_q,    mm_d;
   logic             pm_q,    pm_d;
   logic             count_en;

   // 12-hour BCD hour step; anything outside 01..12 restarts at 01.
   function automatic logic [7:0] hour_inc(input logic [7:0] hh);
      logic [7:0] r;
      if (hh == 8'h09)                       r = 8'h10;
      else if (hh == 8'h10 || hh == 8'h11)   r = hh + 8'h01;
      else if (hh == 8'h12)                  r = 8'h01;
      else if (hh >= 8'h01 && hh <= 8'h08)   r = hh + 8'h01;
      else                                   r = 8'h01;
      return r;
   endfunction

   // BCD minute step 00..59 with wrap and no carry out; invalid values restart at 00.
   function automatic logic [7:0] minute_inc(input logic [7:0] mm);
      logic [7:0] r;
      if (mm[7:4] > 4'd5 || mm[3:0] > 4'd9) r = 8'h00;
      else if (mm[3:0] == 4'd9)             r = (mm[7:4] == 4'd5) ? 8'h00 : {mm[7:4] + 4'd1, 4'd0};
      else                                  r = {mm[7:4], mm[3:0] + 4'd1};
      return r;
   endfunction

   // Next-state logic: FSM transitions, shadow edits, and the prescaler step.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ena_d    = 1'b0;
      load_d   = 1'b0;
      hh_d     = hh_q;
      mm_d     = mm_q;
      pm_d     = pm_q;
      count_en = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mode_btn) begin
               state_d = ST_SET_HH;
               hh_d    = cur_hh;
               mm_d    = cur_mm;
               pm_d    = cur_pm;
               cnt_d   = '0;
            end else begin
               count_en = 1'b1;
            end
         end
         ST_SET_HH: begin
            if (mode_btn) begin
               state_d = ST_SET_MM;
            end else if (inc_btn) begin
               hh_d = hour_inc(hh_q);
               if (hh_q == 8'h11) pm_d = ~pm_q;
            end
         end
         ST_SET_MM: begin
            if (mode_btn) begin
               state_d = ST_COMMIT;
               load_d  = 1'b1;
            end else if (inc_btn) begin
               mm_d = minute_inc(mm_q);
            end
         end
         default: begin
            // The commit cycle is prescaler step zero (counter is parked at 0 here),
            // so the first ena lands TICK_DIV cycles after the load cycle.
            state_d  = ST_RUN;
            count_en = 1'b1;
         end
      endcase
      if (count_en) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            ena_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State and output registers; reset aborts any edit and restores defaults.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         ena_q   <= 1'b0;
         load_q  <= 1'b0;
         hh_q    <= 8'h12;
         mm_q    <= 8'h00;
         pm_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ena_q   <= ena_d;
         load_q  <= load_d;
         hh_q    <= hh_d;
         mm_q    <= mm_d;
         pm_q    <= pm_d;
      end
   end

   assign ena     = ena_q;
   assign load    = load_q;
   assign load_hh = hh_q;
   assign load_mm = mm_q;
   assign load_pm = pm_q;
   assign state   = state_q;

endmodule
